// File: rtl/io_map_pkg.sv
// Shared I/O address map and memory-bus command encodings used by the
// MMIO slave, the RAM wrapper and the CPU.
package io_map_pkg;

  localparam logic [8:0] SW_ADDR  = 9'h140;
  localparam logic [8:0] LED_ADDR = 9'h100;
  localparam logic [8:0] HEX_ADDR = 9'h120;

  typedef enum logic [1:0] {
    MNONE  = 2'b00,
    MREAD  = 2'b01,
    MWRITE = 2'b10
  } mem_cmd_e;

endpackage

// File: rtl/sw_debounce.sv
// Two-flop synchroniser followed by a saturating-counter debouncer.
// The stable output only moves after the synchronised input has matched
// the candidate for a full debounce window.
module sw_debounce #(
  parameter int WIDTH           = 8,
  parameter int DEBOUNCE_CYCLES = 250000,
  parameter int CNT_W           = 23
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] raw,
  output logic [WIDTH-1:0] stable
);

  localparam logic [CNT_W-1:0] LAST_COUNT = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [WIDTH-1:0] sync1;
  logic [WIDTH-1:0] sync2;
  logic [WIDTH-1:0] candidate;
  logic [CNT_W-1:0] count;

  // Bring the asynchronous switch inputs into the clock domain.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync1 <= '0;
      sync2 <= '0;
    end else begin
      sync1 <= raw;
      sync2 <= sync1;
    end
  end

  // Restart the window on any change; publish once the window is full.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      candidate <= '0;
      count     <= '0;
      stable    <= '0;
    end else if (sync2 != candidate) begin
      candidate <= sync2;
      count     <= '0;
    end else if (count < LAST_COUNT) begin
      count <= count + 1'b1;
    end else begin
      stable <= candidate;
    end
  end

endmodule

// File: rtl/mmio_io_ctrl.sv
// Memory-mapped I/O slave: debounced switch readback, LED and display
// registers, and a stretched write-activity indicator on LEDR[9].
module mmio_io_ctrl #(
  parameter int DEBOUNCE_CYCLES = 250000,
  parameter int STRETCH_CYCLES  = 5000000,
  parameter int CNT_W           = 23
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [1:0]  mem_cmd,
  input  logic [8:0]  mem_addr,
  input  logic [15:0] write_data,
  input  logic [7:0]  sw,
  output logic [15:0] read_data,
  output logic        rd_sel,
  output logic [9:0]  ledr,
  output logic [15:0] hex_val
);

  import io_map_pkg::*;

  localparam logic [CNT_W-1:0] STRETCH_LOAD = CNT_W'(STRETCH_CYCLES);

  logic [7:0]       sw_stable;
  logic [7:0]       led_reg;
  logic [15:0]      hex_reg;
  logic [CNT_W-1:0] stretch_cnt;
  logic             is_read;
  logic             is_write;
  logic             led_wr;
  logic             hex_wr;

  sw_debounce #(
    .WIDTH          (8),
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
    .CNT_W          (CNT_W)
  ) u_sw_debounce (
    .clk   (clk),
    .reset (reset),
    .raw   (sw),
    .stable(sw_stable)
  );

  // Command 2'b11 matches neither encoding, so it falls through as idle.
  assign is_read  = (mem_cmd == MREAD);
  assign is_write = (mem_cmd == MWRITE);
  assign led_wr   = is_write && (mem_addr == LED_ADDR);
  assign hex_wr   = is_write && (mem_addr == HEX_ADDR);

  // Latch CPU stores into the LED and display registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      led_reg <= '0;
      hex_reg <= '0;
    end else begin
      if (led_wr) led_reg <= write_data[7:0];
      if (hex_wr) hex_reg <= write_data;
    end
  end

  // Retriggerable pulse stretcher for the write-activity LED.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stretch_cnt <= '0;
    end else if (led_wr || hex_wr) begin
      stretch_cnt <= STRETCH_LOAD;
    end else if (stretch_cnt != '0) begin
      stretch_cnt <= stretch_cnt - 1'b1;
    end
  end

  // Zero-latency read decode; rd_sel tells the bus to take our data.
  always_comb begin
    read_data = 16'h0000;
    rd_sel    = 1'b0;
    if (is_read && (mem_addr == SW_ADDR)) begin
      read_data = {8'h00, sw_stable};
      rd_sel    = 1'b1;
    end else if (is_read && (mem_addr == HEX_ADDR)) begin
      read_data = hex_reg;
      rd_sel    = 1'b1;
    end
  end

  assign ledr    = {(stretch_cnt != '0), (sw_stable != 8'h00), led_reg};
  assign hex_val = hex_reg;

endmodule
